// File: rtl/bram8_arbiter.sv
// bram8_arbiter
// Two requesters (m0, m1) share one dual-port block RAM: port A writes,
// port B is a registered read. Round-robin arbitration. A write from one
// master and a read from the other are granted together when their
// addresses differ. After reset the RAM can optionally be swept to zero
// before any request is served.
module bram8_arbiter #(
    parameter int AW             = 15,
    parameter int DW             = 8,
    parameter int CLEAR_ON_RESET = 1,
    parameter int DUAL_ISSUE     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          bram_ena,
    output logic          bram_wea,
    output logic [AW-1:0] bram_addra,
    output logic [DW-1:0] bram_dina,
    output logic          bram_enb,
    output logic [AW-1:0] bram_addrb,
    input  logic [DW-1:0] bram_doutb,
    output logic          init_done
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] state;
    logic [AW:0] clr_cnt;     // extra MSB marks the end of the sweep
    logic        rr;          // master that wins the next contended cycle
    logic [1:0]  rd_tag;      // read granted last edge, per master

    logic elig0, elig1, pair_ok, gnt0, gnt1;
    logic wr_go, wr_sel1, rd_go, rd_sel1;

    // Both masters share the RAM read bus; rvalid qualifies who owns it.
    assign m0_rdata = bram_doutb;
    assign m1_rdata = bram_doutb;

    // Grant decision for the coming edge.
    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // A master whose ack is high right now is still updating its fields.
        elig0   = (state == ST_RUN) && m0_req && !m0_ack;
        elig1   = (state == ST_RUN) && m1_req && !m1_ack;
        pair_ok = (DUAL_ISSUE != 0) && (m0_we != m1_we) && (m0_addr != m1_addr);
        if (elig0 && elig1) begin
            if (pair_ok) begin
                gnt0 = 1'b1;
                gnt1 = 1'b1;
            end else if (rr) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
        wr_go   = (gnt0 && m0_we) || (gnt1 && m1_we);
        wr_sel1 = gnt1 && m1_we;
        rd_go   = (gnt0 && !m0_we) || (gnt1 && !m1_we);
        rd_sel1 = gnt1 && !m1_we;
    end

    // Clear sweep, grant registration, RAM port drive and read tagging.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt    <= '0;
            rr         <= 1'b0;
            rd_tag     <= 2'b00;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
            init_done  <= 1'b0;
        end else begin
            m0_ack    <= gnt0;
            m1_ack    <= gnt1;
            rd_tag    <= {gnt1 && !m1_we, gnt0 && !m0_we};
            m0_rvalid <= rd_tag[0];
            m1_rvalid <= rd_tag[1];
            bram_ena  <= 1'b0;
            bram_wea  <= 1'b0;
            bram_enb  <= 1'b0;
            // After a lone grant the other master gets priority.
            if (gnt0 ^ gnt1) begin
                rr <= gnt0;
            end
            case (state)
                ST_CLEAR: begin
                    if (!clr_cnt[AW]) begin
                        bram_ena   <= 1'b1;
                        bram_wea   <= 1'b1;
                        bram_addra <= clr_cnt[AW-1:0];
                        bram_dina  <= '0;
                        clr_cnt    <= clr_cnt + 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    if (wr_go) begin
                        bram_ena   <= 1'b1;
                        bram_wea   <= 1'b1;
                        bram_addra <= wr_sel1 ? m1_addr : m0_addr;
                        bram_dina  <= wr_sel1 ? m1_wdata : m0_wdata;
                    end
                    if (rd_go) begin
                        bram_enb   <= 1'b1;
                        bram_addrb <= rd_sel1 ? m1_addr : m0_addr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram8_arbiter.sv
// tb_bram8_arbiter
// Drives two queued requesters into the arbiter, models the block RAM, and
// compares every cycle against a transaction-level reference of the
// arbitration rules and the expected RAM contents.
module tb_bram8_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } op_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_ack, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_ack, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          bram_ena, bram_wea, bram_enb, init_done;
    logic [AW-1:0] bram_addra, bram_addrb;
    logic [DW-1:0] bram_dina, bram_doutb;

    always #5 clk = ~clk;

    bram8_arbiter #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1), .DUAL_ISSUE(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_enb(bram_enb), .bram_addrb(bram_addrb),
        .bram_doutb(bram_doutb), .init_done(init_done)
    );

    // Behavioural block RAM: write on A, registered read on B.
    logic [DW-1:0] bram_mem [DEPTH];
    always @(posedge clk) begin
        if (bram_ena && bram_wea) bram_mem[bram_addra] <= bram_dina;
        if (bram_enb) bram_doutb <= bram_mem[bram_addrb];
    end

    int checks = 0;
    int errors = 0;

    // Requester queues and presentation state.
    op_t q0[$];
    op_t q1[$];
    bit  pres[2];
    bit  gaps;

    // Reference model state.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            running;
    bit            prev_ack[2];
    int            turn;
    bit            pend_rd[2];
    logic [DW-1:0] pend_data[2];

    // Observations used by the directed checks.
    int            cyc;
    int            ack_cyc[2];
    int            rv_cnt[2];
    int            served[2];
    int            back_to_back;
    bit            dut_prev_ack[2];
    logic [DW-1:0] last_rd[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        if (!pres[0] && q0.size() > 0) pres[0] = !gaps || ($urandom_range(0, 3) != 0);
        if (!pres[1] && q1.size() > 0) pres[1] = !gaps || ($urandom_range(0, 3) != 0);
        m0_req = pres[0];
        m1_req = pres[1];
        if (pres[0]) {m0_we, m0_addr, m0_wdata} = q0[0];
        else begin
            m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
        end
        if (pres[1]) {m1_we, m1_addr, m1_wdata} = q1[0];
        else begin
            m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
        end
    endtask

    // One clock: predict what the arbiter owed at the edge, compare, then
    // let the requesters react to the acks they saw.
    task automatic cycle();
        bit  req[2];
        op_t op[2];
        bit  want[2];
        bit  g[2];
        bit  exp_wr, exp_rd;
        op_t wop, rop;
        int  n;
        req[0] = m0_req;
        req[1] = m1_req;
        op[0]  = {m0_we, m0_addr, m0_wdata};
        op[1]  = {m1_we, m1_addr, m1_wdata};
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            want[i] = running && req[i] && !prev_ack[i];
            g[i]    = 1'b0;
        end
        n = int'(want[0]) + int'(want[1]);
        if (n == 2) begin
            if (op[0].we != op[1].we && op[0].addr != op[1].addr) begin
                g[0] = 1'b1;
                g[1] = 1'b1;
            end else begin
                g[turn] = 1'b1;
                turn    = 1 - turn;
            end
        end else if (n == 1) begin
            if (want[0]) begin g[0] = 1'b1; turn = 1; end
            else begin g[1] = 1'b1; turn = 0; end
        end
        exp_wr = 1'b0; exp_rd = 1'b0; wop = '0; rop = '0;
        for (int i = 0; i < 2; i++) begin
            if (g[i] && op[i].we) begin exp_wr = 1'b1; wop = op[i]; end
            if (g[i] && !op[i].we) begin exp_rd = 1'b1; rop = op[i]; end
        end
        check("m0_ack", m0_ack, g[0]);
        check("m1_ack", m1_ack, g[1]);
        check("m0_rvalid", m0_rvalid, pend_rd[0]);
        check("m1_rvalid", m1_rvalid, pend_rd[1]);
        if (pend_rd[0]) check("m0_rdata", m0_rdata, pend_data[0]);
        if (pend_rd[1]) check("m1_rdata", m1_rdata, pend_data[1]);
        check("bram_ena", bram_ena, exp_wr);
        check("bram_wea", bram_wea, exp_wr);
        check("bram_enb", bram_enb, exp_rd);
        if (exp_wr) begin
            check("bram_addra", bram_addra, wop.addr);
            check("bram_dina", bram_dina, wop.wdata);
        end
        if (exp_rd) check("bram_addrb", bram_addrb, rop.addr);
        if (m0_rvalid === 1'b1) begin last_rd[0] = m0_rdata; rv_cnt[0]++; end
        if (m1_rvalid === 1'b1) begin last_rd[1] = m1_rdata; rv_cnt[1]++; end
        if (m0_ack === 1'b1) begin
            ack_cyc[0] = cyc;
            if (dut_prev_ack[0]) back_to_back++;
        end
        if (m1_ack === 1'b1) begin
            ack_cyc[1] = cyc;
            if (dut_prev_ack[1]) back_to_back++;
        end
        dut_prev_ack[0] = (m0_ack === 1'b1);
        dut_prev_ack[1] = (m1_ack === 1'b1);
        for (int i = 0; i < 2; i++) begin
            pend_rd[i] = g[i] && !op[i].we;
            if (pend_rd[i]) pend_data[i] = ref_mem[op[i].addr];
        end
        for (int i = 0; i < 2; i++) begin
            if (g[i] && op[i].we) ref_mem[op[i].addr] = op[i].wdata;
        end
        prev_ack = g;
        if (m0_ack === 1'b1 && q0.size() > 0) begin void'(q0.pop_front()); pres[0] = 1'b0; served[0]++; end
        if (m1_ack === 1'b1 && q1.size() > 0) begin void'(q1.pop_front()); pres[1] = 1'b0; served[1]++; end
        present();
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        pres = '{1'b0, 1'b0};
        present();
        repeat (ncyc) @(negedge clk);
        check("reset_m1_rvalid", m1_rvalid, 1'b0);
        check("reset_outputs",
              {m0_ack, m1_ack, m0_rvalid, m1_rvalid, bram_ena, bram_wea, bram_enb,
               init_done, bram_addra, bram_addrb, bram_dina}, 64'd0);
        running      = 1'b0;
        prev_ack     = '{1'b0, 1'b0};
        dut_prev_ack = '{1'b0, 1'b0};
        pend_rd      = '{1'b0, 1'b0};
        turn         = 0;
        rst          = 1'b0;
    endtask

    task automatic clear_sweep();
        int            idx = 0;
        int            bad = 0;
        int            n = 0;
        bit            seen = 1'b0;
        logic [AW-1:0] first_a = '1;
        while (init_done !== 1'b1 && n < DEPTH + 100) begin
            @(negedge clk);
            n++;
            if (bram_wea === 1'b1) begin
                if (!seen) begin first_a = bram_addra; seen = 1'b1; end
                if (!(bram_ena === 1'b1 && bram_addra === idx[AW-1:0] && bram_dina === '0)) bad++;
                idx++;
            end
            if (m0_ack === 1'b1 || m1_ack === 1'b1 || bram_enb === 1'b1) bad++;
        end
        check("clear_first_addr", first_a, 0);
        check("clear_write_count", idx, DEPTH);
        check("clear_bad_cycles", bad, 0);
        check("init_done", init_done, 1'b1);
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        running = 1'b1;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || pend_rd[0] || pend_rd[1]) && n < max) begin
            cycle();
            n++;
        end
        check({tag, "_drained"},
              (q0.size() == 0 && q1.size() == 0 && !pend_rd[0] && !pend_rd[1]), 1'b1);
        cycle();
    endtask

    task automatic clear_obs();
        last_rd = '{'x, 'x};
        ack_cyc = '{0, 0};
        rv_cnt  = '{0, 0};
        served  = '{0, 0};
    endtask

    initial begin
        int start;
        gaps = 1'b0;
        cyc = 0;
        back_to_back = 0;
        rst = 1'b1;
        pres = '{1'b0, 1'b0};
        present();
        do_reset(2);

        // Test 1: sweep, with an m0 read held waiting through it.
        clear_obs();
        q0.push_back('{we: 1'b0, addr: 15'h1234, wdata: 8'h00});
        present();
        clear_sweep();
        drain("t1", 20);
        check("t1_rdata", last_rd[0], 8'h00);

        // Test 2: m0 write then read back; m1 stays silent.
        clear_obs();
        q0.push_back('{we: 1'b1, addr: 15'h0010, wdata: 8'hA5});
        q0.push_back('{we: 1'b0, addr: 15'h0010, wdata: 8'h00});
        present();
        drain("t2", 20);
        check("t2_rdata", last_rd[0], 8'hA5);
        check("t2_m0_rvalids", rv_cnt[0], 1);
        check("t2_m1_rvalids", rv_cnt[1], 0);

        // Test 3: write and read on different addresses dual-issue.
        clear_obs();
        q0.push_back('{we: 1'b1, addr: 15'h0100, wdata: 8'h3C});
        q1.push_back('{we: 1'b0, addr: 15'h0200, wdata: 8'h00});
        present();
        drain("t3", 20);
        check("t3_same_cycle_ack", ack_cyc[0] == ack_cyc[1] && ack_cyc[0] != 0, 1'b1);
        check("t3_m1_rvalids", rv_cnt[1], 1);
        check("t3_m1_rdata", last_rd[1], 8'h00);

        // Give m1 a lone grant so m0 holds priority for test 4.
        clear_obs();
        q1.push_back('{we: 1'b0, addr: 15'h0100, wdata: 8'h00});
        present();
        drain("t4_prep", 20);
        check("t4_prep_rdata", last_rd[1], 8'h3C);

        // Test 4: same-address write/read serialise, m0 first.
        clear_obs();
        q0.push_back('{we: 1'b1, addr: 15'h0300, wdata: 8'h77});
        q1.push_back('{we: 1'b0, addr: 15'h0300, wdata: 8'h00});
        present();
        drain("t4", 20);
        check("t4_order", ack_cyc[0] != 0 && ack_cyc[0] < ack_cyc[1], 1'b1);
        check("t4_m1_rdata", last_rd[1], 8'h77);

        // Test 5: both masters read back to back; grants must alternate.
        clear_obs();
        for (int i = 0; i < 50; i++) begin
            q0.push_back('{we: 1'b0, addr: AW'($urandom), wdata: 8'h00});
            q1.push_back('{we: 1'b0, addr: AW'($urandom), wdata: 8'h00});
        end
        present();
        start = cyc;
        drain("t5", 300);
        check("t5_m0_served", served[0], 50);
        check("t5_m1_served", served[1], 50);
        check("t5_within_budget", (cyc - start) <= 103, 1'b1);
        check("t5_back_to_back", back_to_back, 0);

        // Random mix with request gaps on a small address window.
        clear_obs();
        gaps = 1'b1;
        for (int i = 0; i < 300; i++) begin
            q0.push_back('{we: 1'($urandom), addr: AW'(15'h0400 + $urandom_range(0, 7)), wdata: DW'($urandom)});
            q1.push_back('{we: 1'($urandom), addr: AW'(15'h0400 + $urandom_range(0, 7)), wdata: DW'($urandom)});
        end
        present();
        drain("rand", 5000);
        check("rand_m0_served", served[0], 300);
        check("rand_m1_served", served[1], 300);
        check("rand_back_to_back", back_to_back, 0);
        gaps = 1'b0;

        // Test 6: reset between m1 ack and m1 rvalid.
        clear_obs();
        q1.push_back('{we: 1'b0, addr: 15'h0010, wdata: 8'h00});
        present();
        for (int i = 0; i < 20 && m1_ack !== 1'b1; i++) cycle();
        check("t6_ack_seen", m1_ack, 1'b1);
        do_reset(1);
        clear_sweep();
        clear_obs();
        q0.push_back('{we: 1'b0, addr: 15'h0010, wdata: 8'h00});
        present();
        drain("t6_post", 20);
        check("t6_post_rdata", last_rd[0], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
